// File: rtl/aes_decryptor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// aes_decryptor : iterative AES-128 decryption, one round per clock, with
//                 round keys regenerated forward then backward on the fly.
// Revision 1.0
// ----------------------------------------------------------------------------

module sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_b
);
  localparam logic [2047:0] c_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  // Entry 0 sits in the top byte, so entry a starts at bit 8*(255-a).
  assign o_b = c_SBOX[{~i_a, 3'b000} +: 8];
endmodule

module inv_sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_b
);
  localparam logic [2047:0] c_INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};
  assign o_b = c_INV_SBOX[{~i_a, 3'b000} +: 8];
endmodule

module aes_decryptor (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  output logic [127:0] plaintext,
  output logic         done,
  output logic         busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EXPAND = 3'd1,
    S_INIT   = 3'd2,
    S_ROUND  = 3'd3,
    S_FINAL  = 3'd4
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic           w_busy;
  logic [127:0]   r_blk;
  logic [127:0]   r_rk;
  logic [127:0]   r_pt;
  logic           r_done;
  logic [3:0]     r_cnt;

  logic [127:0]   w_shr;
  logic [127:0]   w_isb;
  logic [127:0]   w_ark;
  logic [127:0]   w_imc;
  logic [31:0]    w_sb_in;
  logic [31:0]    w_rot;
  logic [31:0]    w_sub;
  logic [31:0]    w_t;
  logic [7:0]     w_rcon;
  logic [127:0]   w_rk_fwd;
  logic [127:0]   w_rk_inv;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Constant-coefficient GF(2^8) product built from an xtime chain.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^
           (k[1] ? x2 : 8'h00) ^ (k[0] ? a  : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
            gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
            gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
            gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
  endfunction

  // InvShiftRows: row r rotates right by r columns, then per-byte inverse S-box.
  for (genvar gr = 0; gr < 4; gr++) begin : g_row
    for (genvar gc = 0; gc < 4; gc++) begin : g_col
      localparam int c_DST = gr + 4 * gc;
      localparam int c_SRC = gr + 4 * ((gc - gr + 4) % 4);
      assign w_shr[127 - 8*c_DST -: 8] = r_blk[127 - 8*c_SRC -: 8];
      inv_sbox u_inv_sbox (
        .i_a (w_shr[127 - 8*c_DST -: 8]),
        .o_b (w_isb[127 - 8*c_DST -: 8])
      );
    end
  end

  assign w_ark = w_isb ^ r_rk;

  for (genvar gk = 0; gk < 4; gk++) begin : g_imc
    assign w_imc[127 - 32*gk -: 32] = inv_mix_col(w_ark[127 - 32*gk -: 32]);
  end

  always_comb begin
    w_rcon = 8'h00;
    case (r_cnt)
      4'd1:    w_rcon = 8'h01;
      4'd2:    w_rcon = 8'h02;
      4'd3:    w_rcon = 8'h04;
      4'd4:    w_rcon = 8'h08;
      4'd5:    w_rcon = 8'h10;
      4'd6:    w_rcon = 8'h20;
      4'd7:    w_rcon = 8'h40;
      4'd8:    w_rcon = 8'h80;
      4'd9:    w_rcon = 8'h1b;
      4'd10:   w_rcon = 8'h36;
      default: w_rcon = 8'h00;
    endcase
  end

  // One S-box word serves both directions: forward uses w3, backward uses the
  // recovered previous w3, which is w3 ^ w2.
  assign w_sb_in = (r_state == S_EXPAND) ? r_rk[31:0] : (r_rk[31:0] ^ r_rk[63:32]);
  assign w_rot   = {w_sb_in[23:0], w_sb_in[31:24]};

  for (genvar gs = 0; gs < 4; gs++) begin : g_ksb
    sbox u_sbox (
      .i_a (w_rot[31 - 8*gs -: 8]),
      .o_b (w_sub[31 - 8*gs -: 8])
    );
  end

  assign w_t = w_sub ^ {w_rcon, 24'h000000};

  always_comb begin
    logic [31:0] f0, f1, f2, f3;
    f0 = r_rk[127:96] ^ w_t;
    f1 = r_rk[95:64]  ^ f0;
    f2 = r_rk[63:32]  ^ f1;
    f3 = r_rk[31:0]   ^ f2;
    w_rk_fwd = {f0, f1, f2, f3};
  end

  assign w_rk_inv = {r_rk[127:96] ^ w_t,
                     r_rk[95:64]  ^ r_rk[127:96],
                     r_rk[63:32]  ^ r_rk[95:64],
                     r_rk[31:0]   ^ r_rk[63:32]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_busy = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:   if (start) w_next = S_EXPAND;
      S_EXPAND: if (r_cnt == 4'd10) w_next = S_INIT;
      S_INIT:   w_next = S_ROUND;
      S_ROUND:  if (r_cnt == 4'd1) w_next = S_FINAL;
      S_FINAL:  w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_blk  <= '0;
      r_rk   <= '0;
      r_pt   <= '0;
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_blk  <= ciphertext;
            r_rk   <= key;
            r_cnt  <= 4'd1;
            r_done <= 1'b0;
          end
        end
        S_EXPAND: begin
          r_rk <= w_rk_fwd;
          if (r_cnt != 4'd10) r_cnt <= r_cnt + 4'd1;
        end
        S_INIT: begin
          r_blk <= r_blk ^ r_rk;
          r_rk  <= w_rk_inv;
          r_cnt <= r_cnt - 4'd1;
        end
        S_ROUND: begin
          r_blk <= w_imc;
          r_rk  <= w_rk_inv;
          r_cnt <= r_cnt - 4'd1;
        end
        S_FINAL: begin
          r_pt   <= w_ark;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign plaintext = r_pt;
  assign done      = r_done;
  assign busy      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_aes_decryptor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_aes_decryptor : vector table plus scoreboard bench for aes_decryptor.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_aes_decryptor;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] ciphertext;
  logic [127:0] key;
  logic [127:0] plaintext;
  logic         done;
  logic         busy;

  always #5 clk = ~clk;

  aes_decryptor dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ciphertext (ciphertext),
    .key        (key),
    .plaintext  (plaintext),
    .done       (done),
    .busy       (busy)
  );

  localparam logic [2047:0] SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  typedef struct { logic [127:0] key; logic [127:0] ct; logic [127:0] pt; } vec_t;
  typedef struct { logic [127:0] pt; int e0; } exp_t;

  vec_t  vecs[7];
  exp_t  sbq[$];
  exp_t  e_pop;
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  logic  done_d = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX_FLAT[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Reference AES-128 encryption, used to build loopback ciphertexts.
  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] k);
    logic [7:0]   s[16];
    logic [7:0]   t[16];
    logic [127:0] rk;
    logic [7:0]   rc;
    logic [31:0]  tmp, w0, w1, w2, w3;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    rk = k;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r+4*c] = sb(s[r+4*((c+r)%4)]);
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rnd < 10) begin
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      w3  = rk[31:0];
      tmp = {sb(w3[23:16]), sb(w3[15:8]), sb(w3[7:0]), sb(w3[31:24])} ^ {rc, 24'h0};
      w0  = rk[127:96] ^ tmp;
      w1  = rk[95:64] ^ w0;
      w2  = rk[63:32] ^ w1;
      w3  = rk[31:0] ^ w2;
      rk  = {w0, w1, w2, w3};
      rc  = xt(rc);
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Scoreboard: every rising edge of done retires one expected result.
  always @(negedge clk) begin
    if (done === 1'b1 && done_d !== 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%h required=no result", plaintext);
      end else begin
        e_pop = sbq.pop_front();
        check128("plaintext", plaintext, e_pop.pt);
        check_int("latency", cyc - e_pop.e0, 21);
      end
    end
    done_d = done;
  end

  task automatic wait_drain(input int maxc);
    for (int i = 0; i < maxc && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout actual=%0d pending required=0 pending", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic launch(input logic [127:0] k, input logic [127:0] ct);
    @(negedge clk);
    start      = 1'b1;
    key        = k;
    ciphertext = ct;
  endtask

  task automatic do_op(input vec_t v);
    launch(v.key, v.ct);
    sbq.push_back('{pt: v.pt, e0: cyc + 1});
    @(negedge clk);
    start      = 1'b0;
    key        = rnd128();
    ciphertext = rnd128();
    check_int("busy_after_e0", int'(busy), 1);
    check_int("done_after_e0", int'(done), 0);
    wait_drain(40);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [127:0] rk_v, rp_v;
    vecs[0] = '{key: C1_KEY, ct: C1_CT, pt: C1_PT};
    vecs[1] = '{key: B_KEY,  ct: B_CT,  pt: B_PT};
    vecs[2] = '{key: 128'h19, ct: aes_enc(128'h57f, 128'h19), pt: 128'h57f};
    vecs[3] = '{key: '0, ct: aes_enc('0, '0), pt: '0};
    vecs[4] = '{key: '1, ct: aes_enc('1, '1), pt: '1};
    for (int i = 5; i < 7; i++) begin
      rk_v = rnd128();
      rp_v = rnd128();
      vecs[i] = '{key: rk_v, ct: aes_enc(rp_v, rk_v), pt: rp_v};
    end

    rst = 1'b1; start = 1'b0; key = '0; ciphertext = '0;
    repeat (2) @(negedge clk);
    check128("reset_plaintext", plaintext, '0);
    check_int("reset_done", int'(done), 0);
    check_int("reset_busy", int'(busy), 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) do_op(vecs[i]);

    // Start during busy must be ignored.
    launch(C1_KEY, C1_CT);
    sbq.push_back('{pt: C1_PT, e0: cyc + 1});
    @(negedge clk);
    start = 1'b0; key = rnd128(); ciphertext = rnd128();
    repeat (4) @(negedge clk);
    start = 1'b1; key = B_KEY; ciphertext = B_CT;
    @(negedge clk);
    start = 1'b0;
    wait_drain(40);
    repeat (5) @(negedge clk);
    check_int("reject_busy_idle", int'(busy), 0);
    check_int("reject_done_hold", int'(done), 1);
    check128("reject_plaintext_hold", plaintext, C1_PT);

    // Reset in the middle of the round phase.
    launch(C1_KEY, C1_CT);
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check128("midrst_plaintext", plaintext, '0);
    check_int("midrst_done", int'(done), 0);
    check_int("midrst_busy", int'(busy), 0);
    rst = 1'b0;
    do_op(vecs[1]);

    // Back-to-back with start held high.
    launch(C1_KEY, C1_CT);
    sbq.push_back('{pt: C1_PT, e0: cyc + 1});
    repeat (22) @(negedge clk);
    check_int("b2b_first_done", int'(done), 1);
    key = B_KEY; ciphertext = B_CT;
    sbq.push_back('{pt: B_PT, e0: cyc + 1});
    @(negedge clk);
    check_int("b2b_done_one_cycle", int'(done), 0);
    check_int("b2b_second_busy", int'(busy), 1);
    start = 1'b0;
    wait_drain(40);
    repeat (3) @(negedge clk);
    check_int("b2b_no_third", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
